// File: rtl/multi_timer.sv
// N_CH independent down-counting timer channels behind a word-addressed bus slave.
// Each channel: prescaler, one-shot/auto-reload, sticky W1C pending bit, maskable IRQ.
module multi_timer #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int PS_W   = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [3:0]        ByteEn,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [N_CH-1:0]   IRQ,
  output logic              irq_any
);

  localparam int SEL_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  logic [SEL_W-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic [31:0]      lane_mask;
  logic [31:0]      din_masked;

  assign ch_sel     = Addr[ADDR_W-1:2];
  assign reg_sel    = Addr[1:0];
  assign lane_mask  = {{8{ByteEn[3]}}, {8{ByteEn[2]}}, {8{ByteEn[1]}}, {8{ByteEn[0]}}};
  assign din_masked = Din & lane_mask;

  state_t            state    [N_CH];
  logic [1:0]        mode     [N_CH];
  logic [CNT_W-1:0]  preset   [N_CH];
  logic [CNT_W-1:0]  count    [N_CH];
  logic [PS_W-1:0]   prescale [N_CH];
  logic [PS_W-1:0]   pscnt    [N_CH];
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   im;
  logic [N_CH-1:0]   pending;

  logic [N_CH-1:0]   wr_ctrl;
  logic [N_CH-1:0]   wr_preset;
  logic [N_CH-1:0]   wr_ps;
  logic [N_CH-1:0]   status_clr;
  logic [3:0]        ctrl_wr   [N_CH];
  logic [CNT_W-1:0]  preset_wr [N_CH];
  logic [PS_W-1:0]   ps_wr     [N_CH];

  // Write decode and byte-lane merge against the current register contents
  always_comb begin
    logic [31:0] merged;
    merged     = '0;
    wr_ctrl    = '0;
    wr_preset  = '0;
    wr_ps      = '0;
    status_clr = '0;
    for (int c = 0; c < N_CH; c++) begin
      ctrl_wr[c]   = '0;
      preset_wr[c] = '0;
      ps_wr[c]     = '0;
      if (WE && ch_sel == SEL_W'(c)) begin
        wr_ctrl[c]   = (reg_sel == 2'd0);
        wr_preset[c] = (reg_sel == 2'd1);
        wr_ps[c]     = (reg_sel == 2'd3);
      end
      ctrl_wr[c]   = ByteEn[0] ? Din[3:0] : {im[c], mode[c], en[c]};
      merged       = (32'(preset[c]) & ~lane_mask) | din_masked;
      preset_wr[c] = merged[CNT_W-1:0];
      merged       = (32'(prescale[c]) & ~lane_mask) | din_masked;
      ps_wr[c]     = merged[PS_W-1:0];
    end
    if (WE && ch_sel == SEL_W'(N_CH) && reg_sel == 2'd0)
      status_clr = din_masked[N_CH-1:0];
  end

  // Bus writes first; FSM assignments come later so a pending set or an EN clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= '0;
      im      <= '0;
      pending <= '0;
      for (int c = 0; c < N_CH; c++) begin
        state[c]    <= S_IDLE;
        mode[c]     <= '0;
        preset[c]   <= '0;
        count[c]    <= '0;
        prescale[c] <= '0;
        pscnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (wr_ctrl[c]) begin
          en[c]   <= ctrl_wr[c][0];
          mode[c] <= ctrl_wr[c][2:1];
          im[c]   <= ctrl_wr[c][3];
        end
        if (wr_preset[c]) preset[c] <= preset_wr[c];
        if (wr_ps[c]) prescale[c] <= ps_wr[c];
        if (status_clr[c]) pending[c] <= 1'b0;

        case (state[c])
          S_IDLE: begin
            if (en[c]) state[c] <= S_LOAD;
          end
          S_LOAD: begin
            count[c] <= preset[c];
            pscnt[c] <= '0;
            state[c] <= S_CNT;
          end
          S_CNT: begin
            if (!en[c]) begin
              state[c] <= S_IDLE;
            end else if (pscnt[c] == prescale[c]) begin
              pscnt[c] <= '0;
              if (count[c] != '0) begin
                count[c] <= count[c] - CNT_W'(1);
              end else begin
                pending[c] <= 1'b1;
                state[c]   <= S_INT;
              end
            end else begin
              pscnt[c] <= pscnt[c] + PS_W'(1);
            end
          end
          default: begin
            if (mode[c] == 2'b01) begin
              state[c] <= S_LOAD;
            end else begin
              en[c]    <= 1'b0;
              state[c] <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Combinational read mux, zero-extended; unmapped addresses read 0
  always_comb begin
    Dout = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == SEL_W'(c)) begin
        case (reg_sel)
          2'd0:    Dout = {28'd0, im[c], mode[c], en[c]};
          2'd1:    Dout = 32'(preset[c]);
          2'd2:    Dout = 32'(count[c]);
          default: Dout = 32'(prescale[c]);
        endcase
      end
    end
    if (ch_sel == SEL_W'(N_CH) && reg_sel == 2'd0)
      Dout = 32'(pending);
  end

  assign IRQ     = pending & im;
  assign irq_any = |IRQ;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (4 channels, 32-bit counters, 16-bit prescale).
// Word address = channel*4 + register; STATUS lives at channel index 4 (address 16).
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Addr;
  logic        WE;
  logic [3:0]  ByteEn;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [3:0]  IRQ;
  logic        irq_any;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_edge = 0;

  multi_timer #(
    .N_CH(4),
    .CNT_W(32),
    .PS_W(16),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Addr(Addr),
    .WE(WE),
    .ByteEn(ByteEn),
    .Din(Din),
    .Dout(Dout),
    .IRQ(IRQ),
    .irq_any(irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // The write lands on the next rising edge; last_edge records that edge's number
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    Addr = a; Din = d; ByteEn = be; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    last_edge = cyc;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    Addr = a;
    #1;
    check_output(tag, Dout, exp);
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic wait_irq(input int bitn, input int limit, output int at, output logic found);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge clk);
      #1;
      if (IRQ[bitn]) begin
        found = 1'b1;
        at = cyc;
      end
    end
  endtask

  initial begin
    int   w, p1, p2, p3, e0, a;
    logic found;

    reset = 1'b0; Addr = '0; WE = 1'b0; ByteEn = '0; Din = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_dout", Dout, 32'h0);
    check_output("reset_irq", 32'(IRQ), 32'h0);
    @(negedge clk) reset = 1'b1;
    check_reg("reset_ctrl0", 5'd0, 32'h0);
    check_reg("reset_status", 5'd16, 32'h0);

    // Byte lanes, read-only COUNT, narrow PRESCALE, unmapped space
    write_reg(5'd1, 32'hAABBCCDD, 4'b0101);
    check_reg("preset_bytelane", 5'd1, 32'h00BB00DD);
    write_reg(5'd2, 32'h0000_1234, 4'hF);
    check_reg("count_readonly", 5'd2, 32'h0);
    write_reg(5'd3, 32'hFFFF_1234, 4'hF);
    check_reg("prescale_narrow", 5'd3, 32'h0000_1234);
    write_reg(5'd20, 32'hFFFF_FFFF, 4'hF);
    check_reg("unmapped_20", 5'd20, 32'h0);
    check_reg("unmapped_17", 5'd17, 32'h0);

    // One-shot on channel 1: PRESET=5, PRESCALE=0 -> pending 8 edges after the CTRL write
    write_reg(5'd5, 32'd5, 4'hF);
    write_reg(5'd7, 32'd0, 4'hF);
    write_reg(5'd4, 32'h9, 4'hF);
    w = last_edge;
    wait_irq(1, 40, p1, found);
    check_output("oneshot_found", 32'(found), 32'h1);
    check_output("oneshot_latency", p1 - w, 32'd8);
    wait_until(p1 + 3);
    check_reg("oneshot_ctrl", 5'd4, 32'h8);
    check_reg("oneshot_count", 5'd6, 32'h0);
    check_reg("oneshot_status", 5'd16, 32'h2);
    check_output("oneshot_irq_any", 32'(irq_any), 32'h1);
    write_reg(5'd16, 32'h2, 4'hF);
    check_output("oneshot_w1c_irq", 32'(IRQ), 32'h0);

    // Auto-reload on channel 0: PRESET=3, PRESCALE=1 -> 2 + 4*2 to first pending, period 10
    write_reg(5'd1, 32'd3, 4'hF);
    write_reg(5'd3, 32'd1, 4'hF);
    write_reg(5'd0, 32'hB, 4'hF);
    w = last_edge;
    wait_irq(0, 40, p1, found);
    check_output("auto_first_found", 32'(found), 32'h1);
    check_output("auto_first_delay", p1 - w, 32'd10);
    write_reg(5'd16, 32'h1, 4'hF);
    wait_irq(0, 40, p2, found);
    check_output("auto_second_found", 32'(found), 32'h1);
    check_output("auto_period", p2 - p1, 32'd10);

    // W1C landing on the same edge as the set: set wins; a later W1C clears
    write_reg(5'd16, 32'h1, 4'hF);
    wait_until(p2 + 9);
    write_reg(5'd16, 32'h1, 4'hF);
    check_reg("w1c_collision", 5'd16, 32'h1);
    write_reg(5'd16, 32'h1, 4'hF);
    check_reg("w1c_clear", 5'd16, 32'h0);

    // Mask: pending still latches with IM=0, IRQ follows IM combinationally
    write_reg(5'd0, 32'h3, 4'hF);
    wait_until(cyc + 12);
    check_reg("mask_status", 5'd16, 32'h1);
    check_output("mask_irq", 32'(IRQ), 32'h0);
    check_output("mask_irq_any", 32'(irq_any), 32'h0);
    write_reg(5'd0, 32'hB, 4'hF);
    check_output("unmask_irq", 32'(IRQ), 32'h1);
    write_reg(5'd0, 32'h0, 4'hF);
    wait_until(cyc + 4);
    write_reg(5'd16, 32'hF, 4'hF);
    check_reg("disable_status", 5'd16, 32'h0);

    // All four channels PRESET=2 one-shot, started on consecutive edges
    write_reg(5'd3, 32'd0, 4'hF);
    for (int ch = 0; ch < 4; ch++) write_reg(5'(ch * 4 + 1), 32'd2, 4'hF);
    for (int ch = 0; ch < 4; ch++) begin
      write_reg(5'(ch * 4), 32'h9, 4'hF);
      if (ch == 0) e0 = last_edge;
    end
    check_output("conc_irq_none", 32'(IRQ), 32'h0);
    wait_until(e0 + 5);
    check_output("conc_irq_ch0", 32'(IRQ), 32'h1);
    wait_until(e0 + 7);
    check_output("conc_irq_ch012", 32'(IRQ), 32'h7);
    wait_until(e0 + 8);
    check_output("conc_irq_all", 32'(IRQ), 32'hF);
    check_output("conc_irq_any", 32'(irq_any), 32'h1);
    wait_until(e0 + 10);
    check_reg("conc_ctrl3", 5'd12, 32'h8);
    write_reg(5'd16, 32'hF, 4'hF);
    check_output("conc_clear_irq", 32'(IRQ), 32'h0);
    check_output("conc_clear_any", 32'(irq_any), 32'h0);

    // Disable channel 2 mid-count; channel 3 keeps running
    write_reg(5'd9, 32'd40, 4'hF);
    write_reg(5'd13, 32'd40, 4'hF);
    write_reg(5'd8, 32'h1, 4'hF);
    a = last_edge;
    write_reg(5'd12, 32'h1, 4'hF);
    wait_until(a + 10);
    write_reg(5'd8, 32'h0, 4'hF);
    wait_until(a + 20);
    check_reg("ch3_running_a", 5'd14, 32'd23);
    wait_until(a + 21);
    check_reg("ch2_frozen_a", 5'd10, 32'd31);
    wait_until(a + 30);
    check_reg("ch3_running_b", 5'd14, 32'd13);
    wait_until(a + 31);
    check_reg("ch2_frozen_b", 5'd10, 32'd31);

    // Asynchronous reset while channel 0 auto-reloads with PRESET=2
    write_reg(5'd0, 32'hB, 4'hF);
    w = last_edge;
    wait_until(w + 8);
    Addr = 5'd2;
    #1;
    check_output("pre_reset_count", Dout, 32'd1);
    check_output("pre_reset_irq", 32'(IRQ), 32'h1);
    #1 reset = 1'b0;
    #1 check_output("async_count", Dout, 32'h0);
    Addr = 5'd0;
    #1 check_output("async_ctrl", Dout, 32'h0);
    Addr = 5'd16;
    #1 check_output("async_status", Dout, 32'h0);
    check_output("async_irq", 32'(IRQ), 32'h0);
    check_output("async_irq_any", 32'(irq_any), 32'h0);
    Addr = 5'd1;
    #1 check_output("async_preset", Dout, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reg("post_reset_count", 5'd2, 32'h0);
    check_reg("post_reset_ctrl", 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
